exc_seq: RTL and testbench

EXC_SEQ -- requirements
Module: exc_seq

---
 rtl/exc_seq.sv | 140 ++++++++++++++
 tb/tb_exc_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exc_seq.sv
// Exception sequencer: on an accepted trap it writes EPC then Cause into CP0,
// redirects fetch to the handler vector, waits in the handler until Eret and
// then redirects fetch back to the EPC readback.
module exc_seq #(
    parameter logic [31:0] VECTOR = 32'h0000_0180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  IntReq,
    input  logic        RiReq,
    input  logic        OvfReq,
    input  logic        SysReq,
    input  logic        Eret,
    input  logic [31:0] PC,
    input  logic [31:0] SrIn,
    input  logic [31:0] EpcIn,
    output logic        CP0Write,
    output logic [4:0]  RegIdx,
    output logic [31:0] DataOut,
    output logic        Exception,
    output logic [4:0]  Cause,
    output logic        Stall,
    output logic        Redirect,
    output logic [31:0] RedirectPC
);

    localparam logic [4:0] CodeInt = 5'd0;
    localparam logic [4:0] CodeSys = 5'd8;
    localparam logic [4:0] CodeRi  = 5'd10;
    localparam logic [4:0] CodeOvf = 5'd12;

    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StCause,
        StJump,
        StHandler,
        StRet
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  code_q, code_d;
    logic        irq_pend;
    logic        req_any;

    // Only SR.IE and SR.IM take part in interrupt qualification.
    logic unused_sr;
    assign unused_sr = ^{SrIn[31:16], SrIn[9:1]};

    assign irq_pend = SrIn[0] & (|(IntReq & SrIn[15:10]));
    assign req_any  = RiReq | OvfReq | SysReq | irq_pend;

    // State, latched PC and latched code; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= 32'h0;
            code_q  <= 5'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
        end
    end

    // Next state: requests are only looked at in idle, Eret only in the handler.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StSave;
                    pc_d    = PC;
                    if (RiReq) begin
                        code_d = CodeRi;
                    end else if (OvfReq) begin
                        code_d = CodeOvf;
                    end else if (SysReq) begin
                        code_d = CodeSys;
                    end else begin
                        code_d = CodeInt;
                    end
                end
            end
            StSave:    state_d = StCause;
            StCause:   state_d = StJump;
            StJump:    state_d = StHandler;
            StHandler: if (Eret) state_d = StRet;
            StRet:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; everything is 0 unless driven.
    always_comb begin
        CP0Write   = 1'b0;
        RegIdx     = 5'h0;
        DataOut    = 32'h0;
        Exception  = 1'b0;
        Cause      = 5'h0;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        unique case (state_q)
            StSave: begin
                CP0Write = 1'b1;
                RegIdx   = RegEpc;
                DataOut  = pc_q;
                Stall    = 1'b1;
            end
            StCause: begin
                CP0Write  = 1'b1;
                RegIdx    = RegCause;
                DataOut   = {25'h0, code_q, 2'b00};
                Cause     = code_q;
                Exception = 1'b1;
                Stall     = 1'b1;
            end
            StJump: begin
                Redirect   = 1'b1;
                RedirectPC = VECTOR;
                Stall      = 1'b1;
            end
            StRet: begin
                Redirect   = 1'b1;
                RedirectPC = EpcIn;
                Stall      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: a directed table of per-cycle vectors, then random
// stimulus, all checked against a queue-based model of the trap sequence.
module tb_exc_seq;

    localparam logic [31:0] VEC = 32'h0000_0180;

    logic        Clk;
    logic        Reset;
    logic [5:0]  IntReq;
    logic        RiReq, OvfReq, SysReq, Eret;
    logic [31:0] PC, SrIn, EpcIn;
    logic        CP0Write;
    logic [4:0]  RegIdx;
    logic [31:0] DataOut;
    logic        Exception;
    logic [4:0]  Cause;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;

    exc_seq #(.VECTOR(VEC)) dut (
        .Clk(Clk), .Reset(Reset), .IntReq(IntReq), .RiReq(RiReq), .OvfReq(OvfReq),
        .SysReq(SysReq), .Eret(Eret), .PC(PC), .SrIn(SrIn), .EpcIn(EpcIn),
        .CP0Write(CP0Write), .RegIdx(RegIdx), .DataOut(DataOut), .Exception(Exception),
        .Cause(Cause), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        w;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        exc;
        logic [4:0]  cause;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  use_epc;  // redirect target is whatever EpcIn shows that cycle
        logic  last;     // final step before the handler is entered
    } step_t;

    typedef struct {
        logic        rst;
        logic [5:0]  intr;
        logic        ri, ovf, sys, eret;
        logic [31:0] pc, sr, epc;
        outs_t       exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: pending output cycles of a running sequence plus a handler flag.
    step_t q[$];
    bit    in_handler = 1'b0;

    function automatic outs_t mk(logic w, logic [4:0] idx, logic [31:0] data, logic exc,
                                 logic [4:0] cause, logic stall, logic redir,
                                 logic [31:0] rpc);
        return {w, idx, data, exc, cause, stall, redir, rpc};
    endfunction

    function automatic vec_t vin(logic rst, logic [5:0] intr, logic ri, logic ovf, logic sys,
                                 logic eret, logic [31:0] pc, logic [31:0] sr,
                                 logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.intr = intr; v.ri = ri; v.ovf = ovf; v.sys = sys; v.eret = eret;
        v.pc = pc; v.sr = sr; v.epc = epc; v.exp = '0;
        return v;
    endfunction

    function automatic vec_t r(vec_t v, outs_t e);
        v.exp = e;
        return v;
    endfunction

    function automatic outs_t model_out(logic [31:0] epc);
        outs_t o;
        o = '0;
        if (q.size() > 0) begin
            o = q[0].o;
            if (q[0].use_epc) o.rpc = epc;
        end
        return o;
    endfunction

    task automatic model_clock(input vec_t v);
        step_t s;
        int    code;
        bit    pend;
        if (v.rst) begin
            q.delete();
            in_handler = 1'b0;
        end else if (q.size() > 0) begin
            s = q.pop_front();
            if (s.last) in_handler = 1'b1;
        end else if (in_handler) begin
            if (v.eret) begin
                in_handler = 1'b0;
                q.push_back('{o: mk(0, 0, 0, 0, 0, 1, 1, 0), use_epc: 1'b1, last: 1'b0});
            end
        end else begin
            pend = v.sr[0] && ((v.intr & v.sr[15:10]) != 6'h0);
            code = -1;
            if (v.ri) code = 10;
            else if (v.ovf) code = 12;
            else if (v.sys) code = 8;
            else if (pend) code = 0;
            if (code >= 0) begin
                q.push_back('{o: mk(1, 14, v.pc, 0, 0, 1, 0, 0), use_epc: 1'b0, last: 1'b0});
                q.push_back('{o: mk(1, 13, 32'(code * 4), 1, 5'(code), 1, 0, 0),
                              use_epc: 1'b0, last: 1'b0});
                q.push_back('{o: mk(0, 0, 0, 0, 0, 1, 1, VEC), use_epc: 1'b0, last: 1'b1});
            end
        end
    endtask

    // One clock: drive after the falling edge, sample 1ns later, then advance the model.
    task automatic step(input vec_t v, input bit chk_model, input bit chk_tbl,
                        input string nm);
        outs_t act, exp;
        @(negedge Clk);
        Reset = v.rst; IntReq = v.intr; RiReq = v.ri; OvfReq = v.ovf; SysReq = v.sys;
        Eret = v.eret; PC = v.pc; SrIn = v.sr; EpcIn = v.epc;
        #1;
        act = {CP0Write, RegIdx, DataOut, Exception, Cause, Stall, Redirect, RedirectPC};
        if (chk_model) begin
            exp = model_out(v.epc);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model_%s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
            end
        end
        if (chk_tbl) begin
            total++;
            if (act !== v.exp) begin
                bad++;
                $display("FAIL table_%s cyc=%0d got=%h want=%h", nm, cyc, act, v.exp);
            end
        end
        model_clock(v);
        cyc++;
    endtask

    vec_t  tbl[$];
    outs_t z, jp;

    initial begin
        vec_t v;
        z  = '0;
        jp = mk(0, 0, 0, 0, 0, 1, 1, 32'h180);

        // Sys trap, handler ignores pulses, Eret+Sys takes Eret, Eret in idle ignored.
        tbl.push_back(r(vin(0, 0, 0, 0, 1, 0, 32'h40, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 14, 32'h40, 0, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 13, 32'h20, 1, 8, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), jp));
        tbl.push_back(r(vin(0, 0, 0, 0, 1, 0, 0, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 1, 1, 0, 0, 32'h1234), z));
        tbl.push_back(r(vin(0, 0, 1, 0, 0, 0, 0, 0, 32'h1234), mk(0, 0, 0, 0, 0, 1, 1, 32'h1234)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 1, 0, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), z));
        // Priority: Ri beats Ovf and an enabled interrupt.
        tbl.push_back(r(vin(0, 6'h01, 1, 1, 0, 0, 32'h100, 32'h401, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 14, 32'h100, 0, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 13, 32'h28, 1, 10, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), jp));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 1, 0, 0, 32'h200), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 32'h200), mk(0, 0, 0, 0, 0, 1, 1, 32'h200)));
        // Interrupt masking by IE, then a held level re-taken after return.
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 32'h300, 32'h800, 0), z));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 32'h300, 32'h800, 0), z));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 32'h300, 32'h801, 0), z));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 0, 32'h801, 0), mk(1, 14, 32'h300, 0, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 0, 32'h801, 0), mk(1, 13, 32'h0, 1, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 0, 32'h801, 0), jp));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 1, 0, 32'h801, 32'h400), z));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 0, 32'h801, 32'h400),
                        mk(0, 0, 0, 0, 0, 1, 1, 32'h400)));
        tbl.push_back(r(vin(0, 6'h02, 0, 0, 0, 0, 32'h500, 32'h801, 0), z));
        // Reset during SAVE aborts; reset beats a same-cycle request.
        tbl.push_back(r(vin(1, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 14, 32'h500, 0, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), z));
        tbl.push_back(r(vin(1, 0, 0, 1, 0, 0, 32'h600, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 1, 0, 0, 32'h600, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 14, 32'h600, 0, 0, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(1, 13, 32'h30, 1, 12, 1, 0, 0)));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), jp));
        tbl.push_back(r(vin(1, 0, 0, 0, 0, 0, 0, 0, 0), z));
        tbl.push_back(r(vin(0, 0, 0, 0, 0, 0, 0, 0, 0), z));

        // Power-up reset: state is unknown before the first edge, so no check there.
        step(vin(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "por");
        step(r(vin(1, 0, 0, 0, 0, 0, 0, 0, 0), z), 1'b1, 1'b1, "reset");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, 1'b1, $sformatf("row%0d", i));
        end

        for (int i = 0; i < 3000; i++) begin
            v = vin($urandom_range(0, 59) == 0, 6'($urandom), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom);
            v.sr[0] = ($urandom_range(0, 3) != 0);
            step(v, 1'b1, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
